// File: rtl/imsic_csr_initiator.sv
// Hart-side initiator for the IMSIC interrupt-file CSR channel.
// One indirect CSR access in flight: issue, wait for data, hold response.
module imsic_csr_initiator #(
   parameter int NR_INTP_FILES   = 7,
   parameter int XLEN            = 64,
   parameter int INTP_FILE_WIDTH = 3,
   parameter int TIMEOUT_CYCLES  = 16,
   parameter int TMO_WIDTH       = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_req_vld,
   output logic                       o_req_rdy,
   input  logic [11:0]                i_req_addr,
   input  logic [1:0]                 i_req_priv,
   input  logic                       i_req_v,
   input  logic [5:0]                 i_req_vgein,
   input  logic                       i_req_wr,
   input  logic [1:0]                 i_req_op,
   input  logic [XLEN-1:0]            i_req_wdata,
   output logic                       o_rsp_vld,
   input  logic                       i_rsp_rdy,
   output logic [XLEN-1:0]            o_rsp_rdata,
   output logic                       o_rsp_illegal,
   output logic                       o_rsp_timeout,
   output logic [11:0]                o_csr_addr,
   output logic                       o_csr_rd,
   output logic [INTP_FILE_WIDTH-1:0] o_intp_file_sel,
   output logic                       o_csr_v,
   output logic                       o_csr_wdata_vld,
   output logic [XLEN-1:0]            o_csr_wdata,
   output logic [1:0]                 o_csr_wdata_op,
   input  logic                       i_csr_rdata_vld,
   input  logic [XLEN-1:0]            i_csr_rdata,
   input  logic                       i_csr_illegal
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [5:0] MAX_VGEIN = 6'(NR_INTP_FILES - 2);
   localparam logic [TMO_WIDTH-1:0] TMO_LIM = TMO_WIDTH'(TIMEOUT_CYCLES);

   state_t                     state_q;
   logic [TMO_WIDTH-1:0]       cnt_q;
   logic                       req_rdy_q;
   logic                       rsp_vld_q;
   logic [XLEN-1:0]            rsp_rdata_q;
   logic                       rsp_ill_q;
   logic                       rsp_tmo_q;
   logic                       csr_rd_q;
   logic [11:0]                csr_addr_q;
   logic [INTP_FILE_WIDTH-1:0] csr_file_q;
   logic                       csr_v_q;
   logic                       csr_wvld_q;
   logic [XLEN-1:0]            csr_wdata_q;
   logic [1:0]                 csr_op_q;

   logic [INTP_FILE_WIDTH-1:0] file_sel_d;
   logic                       loc_ill_d;
   logic [TMO_WIDTH-1:0]       cnt_d;

   always_comb begin
      file_sel_d = '0;
      if (i_req_priv == 2'd1) begin
         file_sel_d = i_req_v
            ? INTP_FILE_WIDTH'(i_req_vgein) + INTP_FILE_WIDTH'(1)
            : INTP_FILE_WIDTH'(1);
      end
      loc_ill_d = 1'b0;
      if (i_req_v && (i_req_vgein == 6'd0 || i_req_vgein > MAX_VGEIN))
         loc_ill_d = 1'b1;
      if (i_req_priv != 2'd1 && i_req_priv != 2'd3)
         loc_ill_d = 1'b1;
      if (i_req_wr && i_req_op == 2'b00)
         loc_ill_d = 1'b1;
      cnt_d = cnt_q + TMO_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         req_rdy_q   <= 1'b1;
         rsp_vld_q   <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_ill_q   <= 1'b0;
         rsp_tmo_q   <= 1'b0;
         csr_rd_q    <= 1'b0;
         csr_addr_q  <= '0;
         csr_file_q  <= '0;
         csr_v_q     <= 1'b0;
         csr_wvld_q  <= 1'b0;
         csr_wdata_q <= '0;
         csr_op_q    <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (i_req_vld) begin
                  req_rdy_q <= 1'b0;
                  if (loc_ill_d) begin
                     state_q     <= RESP;
                     rsp_vld_q   <= 1'b1;
                     rsp_rdata_q <= '0;
                     rsp_ill_q   <= 1'b1;
                     rsp_tmo_q   <= 1'b0;
                  end else begin
                     state_q     <= ISSUE;
                     csr_rd_q    <= 1'b1;
                     csr_addr_q  <= i_req_addr;
                     csr_file_q  <= file_sel_d;
                     csr_v_q     <= i_req_v;
                     csr_wvld_q  <= i_req_wr;
                     csr_wdata_q <= i_req_wdata;
                     csr_op_q    <= i_req_op;
                  end
               end
            end
            ISSUE: begin
               state_q     <= WAIT;
               cnt_q       <= '0;
               csr_rd_q    <= 1'b0;
               csr_addr_q  <= '0;
               csr_file_q  <= '0;
               csr_v_q     <= 1'b0;
               csr_wvld_q  <= 1'b0;
               csr_wdata_q <= '0;
               csr_op_q    <= '0;
            end
            WAIT: begin
               if (i_csr_rdata_vld) begin
                  state_q     <= RESP;
                  rsp_vld_q   <= 1'b1;
                  rsp_rdata_q <= i_csr_rdata;
                  rsp_ill_q   <= i_csr_illegal;
                  rsp_tmo_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_d;
                  // data arriving on the final wait cycle still wins
                  if (cnt_d == TMO_LIM) begin
                     state_q     <= RESP;
                     rsp_vld_q   <= 1'b1;
                     rsp_rdata_q <= '0;
                     rsp_ill_q   <= 1'b1;
                     rsp_tmo_q   <= 1'b1;
                  end
               end
            end
            RESP: begin
               if (i_rsp_rdy) begin
                  state_q     <= IDLE;
                  req_rdy_q   <= 1'b1;
                  rsp_vld_q   <= 1'b0;
                  rsp_rdata_q <= '0;
                  rsp_ill_q   <= 1'b0;
                  rsp_tmo_q   <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_req_rdy       = req_rdy_q;
   assign o_rsp_vld       = rsp_vld_q;
   assign o_rsp_rdata     = rsp_rdata_q;
   assign o_rsp_illegal   = rsp_ill_q;
   assign o_rsp_timeout   = rsp_tmo_q;
   assign o_csr_rd        = csr_rd_q;
   assign o_csr_addr      = csr_addr_q;
   assign o_intp_file_sel = csr_file_q;
   assign o_csr_v         = csr_v_q;
   assign o_csr_wdata_vld = csr_wvld_q;
   assign o_csr_wdata     = csr_wdata_q;
   assign o_csr_wdata_op  = csr_op_q;

endmodule
